// File: rtl/tile_invert.sv
// tile_invert: tracks pixel position on the delayed video stream and inverts
// the RGB of pixels whose 128x128 tile is flagged dark in a double-buffered
// per-frame tile map. Sync signals and pixels leave with a fixed 2-cycle delay.
module tile_invert #(
  parameter int H_TILES    = 15,
  parameter int V_TILES    = 9,
  parameter int TILE_SHIFT = 7,
  parameter int XW         = 12,
  parameter int YW         = 11,
  parameter int CW         = 8
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic                         en_i,
  input  logic [H_TILES*V_TILES-1:0]   dark_i,
  input  logic                         dark_vld_i,
  input  logic                         vs_i,
  input  logic                         hs_i,
  input  logic                         de_i,
  input  logic [3*CW-1:0]              rgb_i,
  output logic                         vs_o,
  output logic                         hs_o,
  output logic                         de_o,
  output logic [3*CW-1:0]              rgb_o,
  output logic [XW-1:0]                x_o,
  output logic [YW-1:0]                y_o
);

  localparam int MAP_W = H_TILES * V_TILES;
  localparam int IDX_W = $clog2(MAP_W);
  localparam int PW    = 3 * CW;

  // Saturating increment so a stuck data enable never wraps the x counter.
  function automatic logic [XW-1:0] sat_inc_x(input logic [XW-1:0] v);
    return (&v) ? v : v + XW'(1);
  endfunction

  // Saturating increment so a frame without vsync never wraps the y counter.
  function automatic logic [YW-1:0] sat_inc_y(input logic [YW-1:0] v);
    return (&v) ? v : v + YW'(1);
  endfunction

  // Blank outside active video, otherwise optionally invert every channel.
  function automatic logic [PW-1:0] shade(input logic de, input logic inv,
                                          input logic [PW-1:0] px);
    if (!de) return '0;
    if (inv) return ~px;
    return px;
  endfunction

  // Map bit of the tile holding (x, y); coordinates beyond the grid clamp
  // to the last tile column/row instead of aliasing into the next row.
  function automatic logic [IDX_W-1:0] tile_index(input logic [XW-1:0] x,
                                                  input logic [YW-1:0] y);
    logic [XW-1:0]    tx_raw;
    logic [YW-1:0]    ty_raw;
    logic [IDX_W-1:0] tx;
    logic [IDX_W-1:0] ty;
    tx_raw = x >> TILE_SHIFT;
    ty_raw = y >> TILE_SHIFT;
    tx = (tx_raw > XW'(H_TILES - 1)) ? IDX_W'(H_TILES - 1) : IDX_W'(tx_raw);
    ty = (ty_raw > YW'(V_TILES - 1)) ? IDX_W'(V_TILES - 1) : IDX_W'(ty_raw);
    return ty * IDX_W'(H_TILES) + tx;
  endfunction

  logic             vs_q;
  logic             de_q;
  logic [XW-1:0]    x_cnt;
  logic [YW-1:0]    y_cnt;
  logic [MAP_W-1:0] pend_map;
  logic [MAP_W-1:0] act_map;
  logic             pend_flag;
  logic             en_frame;

  logic             vs_rise;
  logic             de_fall;
  logic [IDX_W-1:0] tile_idx;
  logic             inv_p0;

  logic             vs_p1;
  logic             hs_p1;
  logic             de_p1;
  logic [PW-1:0]    rgb_p1;
  logic [XW-1:0]    x_p1;
  logic [YW-1:0]    y_p1;
  logic             inv_p1;

  assign vs_rise  = vs_i & ~vs_q;
  assign de_fall  = ~de_i & de_q;
  assign tile_idx = tile_index(x_cnt, y_cnt);
  assign inv_p0   = de_i & en_frame & act_map[tile_idx];

  // Edge detectors and input-side pixel position counters.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      vs_q  <= 1'b0;
      de_q  <= 1'b0;
      x_cnt <= '0;
      y_cnt <= '0;
    end else begin
      vs_q <= vs_i;
      de_q <= de_i;
      if (de_i)         x_cnt <= sat_inc_x(x_cnt);
      else if (de_fall) x_cnt <= '0;
      if (vs_rise)      y_cnt <= '0;
      else if (de_fall) y_cnt <= sat_inc_y(y_cnt);
    end
  end

  // Tile map double buffer: a newly captured map only becomes active at the
  // next frame start; a capture coinciding with that start waits one more.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pend_map  <= '0;
      act_map   <= '0;
      pend_flag <= 1'b0;
      en_frame  <= 1'b0;
    end else begin
      if (vs_rise) en_frame <= en_i;
      if (vs_rise && pend_flag) act_map <= pend_map;
      if (dark_vld_i) begin
        pend_map  <= dark_i;
        pend_flag <= 1'b1;
      end else if (vs_rise && pend_flag) begin
        pend_flag <= 1'b0;
      end
    end
  end

  // ---- stage 1: register sync, pixel, position and inversion decision ----
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      vs_p1  <= 1'b0;
      hs_p1  <= 1'b0;
      de_p1  <= 1'b0;
      rgb_p1 <= '0;
      x_p1   <= '0;
      y_p1   <= '0;
      inv_p1 <= 1'b0;
    end else begin
      vs_p1  <= vs_i;
      hs_p1  <= hs_i;
      de_p1  <= de_i;
      rgb_p1 <= rgb_i;
      x_p1   <= x_cnt;
      y_p1   <= y_cnt;
      inv_p1 <= inv_p0;
    end
  end

  // ---- stage 2: apply blanking/inversion and drive the outputs ----
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      vs_o  <= 1'b0;
      hs_o  <= 1'b0;
      de_o  <= 1'b0;
      rgb_o <= '0;
      x_o   <= '0;
      y_o   <= '0;
    end else begin
      vs_o  <= vs_p1;
      hs_o  <= hs_p1;
      de_o  <= de_p1;
      rgb_o <= shade(de_p1, inv_p1, rgb_p1);
      x_o   <= x_p1;
      y_o   <= y_p1;
    end
  end

endmodule

// File: tb/tb_tile_invert.sv
// tb_tile_invert: directed scenarios plus randomized video against a
// frame-level reference model of position tracking and tile-map inversion.
module tb_tile_invert;
  localparam int H_TILES = 15, V_TILES = 9, TILE_SHIFT = 7, XW = 12, YW = 11, CW = 8;
  localparam int MAP_W = H_TILES * V_TILES;
  localparam int PW = 3 * CW;
  localparam int OW = 3 + PW + XW + YW;
  localparam int X_MAX = (1 << XW) - 1;
  localparam int Y_MAX = (1 << YW) - 1;
  localparam int TILE = 1 << TILE_SHIFT;

  logic clk = 1'b0;
  logic rst_n;
  logic en;
  logic [MAP_W-1:0] dark;
  logic dark_vld;
  logic vs, hs, de;
  logic [PW-1:0] rgb;
  logic vs_o, hs_o, de_o;
  logic [PW-1:0] rgb_o;
  logic [XW-1:0] x_o;
  logic [YW-1:0] y_o;

  always #5 clk = ~clk;

  tile_invert #(.H_TILES(H_TILES), .V_TILES(V_TILES), .TILE_SHIFT(TILE_SHIFT),
                .XW(XW), .YW(YW), .CW(CW)) dut (
    .clk_i(clk), .rst_ni(rst_n), .en_i(en), .dark_i(dark), .dark_vld_i(dark_vld),
    .vs_i(vs), .hs_i(hs), .de_i(de), .rgb_i(rgb),
    .vs_o(vs_o), .hs_o(hs_o), .de_o(de_o), .rgb_o(rgb_o), .x_o(x_o), .y_o(y_o));

  int errors = 0;
  int checks = 0;

  // reference model state
  int m_x, m_y;
  bit m_vs_prev, m_de_prev, m_en, m_has_pending;
  logic [MAP_W-1:0] m_pending, m_active;
  logic [OW-1:0] pipe1;

  logic [OW-1:0] exp_vec, got_vec;
  logic got_vs, got_hs, got_de;
  logic [PW-1:0] got_rgb;
  logic [XW-1:0] got_x;
  logic [YW-1:0] got_y;

  function automatic logic [MAP_W-1:0] rand_map();
    logic [159:0] r;
    r = {$urandom, $urandom, $urandom, $urandom, $urandom};
    return r[MAP_W-1:0];
  endfunction

  task automatic model_clear();
    m_x = 0; m_y = 0; m_vs_prev = 0; m_de_prev = 0; m_en = 0; m_has_pending = 0;
    m_pending = '0; m_active = '0; pipe1 = '0;
  endtask

  // Applies one cycle of video, predicts its output, and samples the DUT
  // output that belongs to the cycle driven before this one.
  task automatic drive_cycle(input bit v, input bit h, input bit d, input logic [PW-1:0] p);
    logic [OW-1:0] m;
    logic [PW-1:0] px;
    int tx, ty;
    bit inv, frame_start, line_end;
    vs = v; hs = h; de = d; rgb = p;
    tx = m_x / TILE; if (tx > H_TILES - 1) tx = H_TILES - 1;
    ty = m_y / TILE; if (ty > V_TILES - 1) ty = V_TILES - 1;
    inv = d && m_en && m_active[ty * H_TILES + tx];
    px = !d ? '0 : (inv ? ~p : p);
    m = {v, h, d, px, XW'(m_x), YW'(m_y)};
    frame_start = v && !m_vs_prev;
    line_end = !d && m_de_prev;
    if (d) m_x = (m_x < X_MAX) ? m_x + 1 : X_MAX;
    else if (line_end) m_x = 0;
    if (frame_start) m_y = 0;
    else if (line_end) m_y = (m_y < Y_MAX) ? m_y + 1 : Y_MAX;
    if (frame_start) m_en = en;
    if (frame_start && m_has_pending) begin m_active = m_pending; m_has_pending = 0; end
    if (dark_vld) begin m_pending = dark; m_has_pending = 1; end
    m_vs_prev = v; m_de_prev = d;
    @(posedge clk); #1;
    dark_vld = 1'b0;
    exp_vec = pipe1;
    pipe1 = m;
    got_vs = vs_o; got_hs = hs_o; got_de = de_o; got_rgb = rgb_o; got_x = x_o; got_y = y_o;
    got_vec = {vs_o, hs_o, de_o, rgb_o, x_o, y_o};
  endtask

  task automatic test_reset();
    logic [PW-1:0] p;
    for (int i = 0; i < 6; i++) drive_cycle(0, 0, 1, PW'($urandom));
    drive_cycle(0, 1, 0, 0);
    for (int i = 0; i < 4; i++) drive_cycle(0, 0, 1, PW'($urandom));
    vs = 1; hs = 1; de = 1; rgb = 24'hABCDEF;
    rst_n = 1'b0; #1;
    checks++;
    if ({vs_o, hs_o, de_o, rgb_o, x_o, y_o} !== '0) begin
      errors++; $display("FAIL reset_immediate got=%h exp=0", {vs_o, hs_o, de_o, rgb_o, x_o, y_o});
    end
    repeat (3) @(posedge clk); #1;
    checks++;
    if ({vs_o, hs_o, de_o, rgb_o, x_o, y_o} !== '0) begin
      errors++; $display("FAIL reset_held got=%h exp=0", {vs_o, hs_o, de_o, rgb_o, x_o, y_o});
    end
    model_clear();
    vs = 0; hs = 0; de = 0; rgb = '0;
    rst_n = 1'b1;
    p = 24'h0A0B0C;
    drive_cycle(0, 0, 1, p);
    checks++;
    if (got_de !== 1'b0) begin errors++; $display("FAIL reset_early_de got=%b exp=0", got_de); end
    drive_cycle(0, 0, 0, 0);
    checks++;
    if (got_de !== 1'b1 || got_x !== '0 || got_y !== '0 || got_rgb !== p) begin
      errors++; $display("FAIL reset_first_pixel got de=%b x=%0d y=%0d rgb=%h exp de=1 x=0 y=0 rgb=%h",
                         got_de, got_x, got_y, got_rgb, p);
    end
  endtask

  task automatic test_latency();
    en = 1'b0;
    drive_cycle(0, 1, 1, 24'h123456);
    checks++;
    if (got_de !== 1'b0 || got_hs !== 1'b0) begin
      errors++; $display("FAIL latency_early got de=%b hs=%b exp 0 0", got_de, got_hs);
    end
    drive_cycle(0, 0, 0, 0);
    checks++;
    if (got_de !== 1'b1 || got_hs !== 1'b1 || got_vs !== 1'b0 || got_rgb !== 24'h123456) begin
      errors++; $display("FAIL latency_pixel got de=%b hs=%b vs=%b rgb=%h exp 1 1 0 123456",
                         got_de, got_hs, got_vs, got_rgb);
    end
    drive_cycle(1, 0, 0, 0);
    drive_cycle(0, 0, 0, 0);
    checks++;
    if (got_vs !== 1'b1 || got_de !== 1'b0) begin
      errors++; $display("FAIL latency_vs got vs=%b de=%b exp 1 0", got_vs, got_de);
    end
    drive_cycle(0, 0, 0, 0);
    checks++;
    if (got_vec !== exp_vec) begin errors++; $display("FAIL latency_model got=%h exp=%h", got_vec, exp_vec); end
  endtask

  task automatic test_inversion();
    bit seen127, seen128;
    seen127 = 0; seen128 = 0;
    en = 1'b1;
    dark = '0; dark[16] = 1'b1; dark_vld = 1'b1;
    drive_cycle(0, 0, 0, 0);
    drive_cycle(1, 0, 0, 0);
    drive_cycle(1, 0, 0, 0);
    drive_cycle(0, 0, 0, 0);
    for (int l = 0; l < 128; l++) begin
      drive_cycle(0, 0, 1, PW'($urandom));
      checks++;
      if (got_vec !== exp_vec) begin errors++; $display("FAIL inversion_model got=%h exp=%h", got_vec, exp_vec); end
      drive_cycle(0, 1, 0, 0);
      checks++;
      if (got_vec !== exp_vec) begin errors++; $display("FAIL inversion_model got=%h exp=%h", got_vec, exp_vec); end
    end
    for (int i = 0; i < 132; i++) begin
      drive_cycle(0, 0, (i < 130), 24'h00FF10);
      checks++;
      if (got_vec !== exp_vec) begin errors++; $display("FAIL inversion_model got=%h exp=%h", got_vec, exp_vec); end
      if (got_de && got_y == 128 && got_x == 127) begin
        seen127 = 1; checks++;
        if (got_rgb !== 24'h00FF10) begin errors++; $display("FAIL inversion_x127 got=%h exp=00ff10", got_rgb); end
      end
      if (got_de && got_y == 128 && got_x == 128) begin
        seen128 = 1; checks++;
        if (got_rgb !== 24'hFF00EF) begin errors++; $display("FAIL inversion_x128 got=%h exp=ff00ef", got_rgb); end
      end
    end
    checks++;
    if (!(seen127 && seen128)) begin
      errors++; $display("FAIL inversion_seen got=%b%b exp=11", seen127, seen128);
    end
  endtask

  task automatic test_double_buffer();
    logic [MAP_W-1:0] b;
    bit seen_old, seen_new;
    seen_old = 0; seen_new = 0;
    b = rand_map(); b[0] = 1'b1;
    drive_cycle(1, 0, 0, 0);
    drive_cycle(0, 0, 0, 0);
    for (int i = 0; i < 6; i++) begin
      if (i == 2) begin dark = b; dark_vld = 1'b1; end
      drive_cycle(0, 0, (i < 4), 24'hA5A5A5);
      checks++;
      if (got_vec !== exp_vec) begin errors++; $display("FAIL dbuf_model got=%h exp=%h", got_vec, exp_vec); end
      if (got_de && got_x == 0 && got_y == 0) begin
        seen_old = 1; checks++;
        if (got_rgb !== 24'hA5A5A5) begin errors++; $display("FAIL dbuf_old_map got=%h exp=a5a5a5", got_rgb); end
      end
    end
    drive_cycle(1, 0, 0, 0);
    drive_cycle(0, 0, 0, 0);
    for (int i = 0; i < 6; i++) begin
      drive_cycle(0, 0, (i < 4), 24'hA5A5A5);
      checks++;
      if (got_vec !== exp_vec) begin errors++; $display("FAIL dbuf_model got=%h exp=%h", got_vec, exp_vec); end
      if (got_de && got_x == 0 && got_y == 0) begin
        seen_new = 1; checks++;
        if (got_rgb !== 24'h5A5A5A) begin errors++; $display("FAIL dbuf_new_map got=%h exp=5a5a5a", got_rgb); end
      end
    end
    checks++;
    if (!(seen_old && seen_new)) begin errors++; $display("FAIL dbuf_seen got=%b%b exp=11", seen_old, seen_new); end
  endtask

  task automatic test_coincident();
    logic [MAP_W-1:0] a, b;
    bit seen1, seen2;
    seen1 = 0; seen2 = 0;
    a = rand_map(); a[0] = 1'b0;
    b = rand_map(); b[0] = 1'b1;
    dark = a; dark_vld = 1'b1;
    drive_cycle(0, 0, 0, 0);
    dark = b; dark_vld = 1'b1;
    drive_cycle(1, 0, 0, 0);
    drive_cycle(0, 0, 0, 0);
    for (int i = 0; i < 5; i++) begin
      drive_cycle(0, 0, (i < 3), 24'h3C3C3C);
      checks++;
      if (got_vec !== exp_vec) begin errors++; $display("FAIL coinc_model got=%h exp=%h", got_vec, exp_vec); end
      if (got_de && got_x == 0) begin
        seen1 = 1; checks++;
        if (got_rgb !== 24'h3C3C3C) begin errors++; $display("FAIL coinc_first_frame got=%h exp=3c3c3c", got_rgb); end
      end
    end
    drive_cycle(1, 0, 0, 0);
    drive_cycle(0, 0, 0, 0);
    for (int i = 0; i < 5; i++) begin
      drive_cycle(0, 0, (i < 3), 24'h3C3C3C);
      checks++;
      if (got_vec !== exp_vec) begin errors++; $display("FAIL coinc_model got=%h exp=%h", got_vec, exp_vec); end
      if (got_de && got_x == 0) begin
        seen2 = 1; checks++;
        if (got_rgb !== 24'hC3C3C3) begin errors++; $display("FAIL coinc_second_frame got=%h exp=c3c3c3", got_rgb); end
      end
    end
    checks++;
    if (!(seen1 && seen2)) begin errors++; $display("FAIL coinc_seen got=%b%b exp=11", seen1, seen2); end
  endtask

  task automatic test_clamp();
    logic [MAP_W-1:0] c;
    logic [PW-1:0] pix [0:2199];
    int n_clamped;
    n_clamped = 0;
    c = rand_map(); c[14] = 1'b1; c[15] = 1'b0;
    en = 1'b1; dark = c; dark_vld = 1'b1;
    drive_cycle(0, 0, 0, 0);
    drive_cycle(1, 0, 0, 0);
    drive_cycle(0, 0, 0, 0);
    for (int i = 0; i < 2201; i++) begin
      if (i < 2200) pix[i] = PW'($urandom);
      drive_cycle(0, 0, (i < 2200), (i < 2200) ? pix[i] : 24'hFFFFFF);
      checks++;
      if (got_vec !== exp_vec) begin errors++; $display("FAIL clamp_model got=%h exp=%h", got_vec, exp_vec); end
      if (got_de && got_x >= 1920) begin
        n_clamped++; checks++;
        if (got_rgb !== ~pix[got_x]) begin
          errors++; $display("FAIL clamp_pixel x=%0d got=%h exp=%h", got_x, got_rgb, ~pix[got_x]);
        end
      end
    end
    drive_cycle(0, 0, 0, 24'hFFFFFF);
    checks++;
    if (got_de !== 1'b0 || got_rgb !== '0) begin
      errors++; $display("FAIL clamp_blank got de=%b rgb=%h exp de=0 rgb=000000", got_de, got_rgb);
    end
    checks++;
    if (n_clamped != 280) begin errors++; $display("FAIL clamp_count got=%0d exp=280", n_clamped); end
  endtask

  task automatic test_saturation();
    drive_cycle(0, 0, 0, 0);
    for (int i = 0; i < 4200; i++) begin
      drive_cycle(0, 0, 1, PW'($urandom));
      checks++;
      if (got_vec !== exp_vec) begin errors++; $display("FAIL sat_model got=%h exp=%h", got_vec, exp_vec); end
    end
    checks++;
    if (got_x !== XW'(X_MAX) || got_de !== 1'b1) begin
      errors++; $display("FAIL sat_x got x=%0d de=%b exp x=%0d de=1", got_x, got_de, X_MAX);
    end
    for (int l = 0; l < 2050; l++) begin
      drive_cycle(0, 0, 0, 0);
      drive_cycle(0, 0, 1, PW'($urandom));
      checks++;
      if (got_vec !== exp_vec) begin errors++; $display("FAIL sat_model got=%h exp=%h", got_vec, exp_vec); end
    end
    drive_cycle(0, 0, 0, 0);
    drive_cycle(0, 0, 1, 24'h010203);
    drive_cycle(0, 0, 0, 0);
    checks++;
    if (got_de !== 1'b1 || got_y !== YW'(Y_MAX) || got_x !== '0) begin
      errors++; $display("FAIL sat_y got de=%b y=%0d x=%0d exp de=1 y=%0d x=0", got_de, got_y, got_x, Y_MAX);
    end
  endtask

  task automatic test_random();
    bit v, d;
    for (int i = 0; i < 6000; i++) begin
      v = ($urandom_range(0, 299) < 3);
      d = ($urandom_range(0, 9) < 7);
      en = 1'($urandom);
      if ($urandom_range(0, 59) == 0) begin dark = rand_map(); dark_vld = 1'b1; end
      drive_cycle(v, 1'($urandom), d, PW'($urandom));
      checks++;
      if (got_vec !== exp_vec) begin errors++; $display("FAIL random_model got=%h exp=%h", got_vec, exp_vec); end
    end
  endtask

  initial begin
    rst_n = 1'b0; en = 1'b0; dark = '0; dark_vld = 1'b0;
    vs = 1'b0; hs = 1'b0; de = 1'b0; rgb = '0;
    model_clear();
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    test_reset();
    test_latency();
    test_inversion();
    test_double_buffer();
    test_coincident();
    test_clamp();
    test_saturation();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
